ascii_cmd_decoder: RTL

// - ASCII-to-binary command parser on the UART RX FIFO read side; the inverse of the digit-to-ASCII TX path.
// - Pops bytes from the RX FIFO and parses lines of the form <letter><0..MAX_DIGITS decimal digits><CR|LF>.
// - Emits one registered command/value strobe per accepted line, or an error strobe for malformed lines.
// - Feeds the clock/sensor control logic (e.g. "S1234\r" -> cmd 'S', value 1234).
//

---
 rtl/ascii_cmd_decoder_if.sv | 28 ++
 rtl/ascii_cmd_decoder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ascii_cmd_decoder_if.sv
// RX-FIFO read port, TX echo port and parsed-command outputs of ascii_cmd_decoder.
// The decoder connects through the slave modport; the driving side uses master.
interface ascii_cmd_decoder_if #(
    parameter int VAL_W = 14
);
    logic             iRxEmpty;
    logic [7:0]       iRxData;
    logic             oRxPop;
    logic             iTxFull;
    logic [7:0]       oEchoData;
    logic             oEchoPush;
    logic [7:0]       oCmd;
    logic [VAL_W-1:0] oValue;
    logic [2:0]       oDigitCnt;
    logic             oValid;
    logic             oErr;
    logic             oBusy;

    modport slave (
        input  iRxEmpty, iRxData, iTxFull,
        output oRxPop, oEchoData, oEchoPush, oCmd, oValue, oDigitCnt, oValid, oErr, oBusy
    );

    modport master (
        output iRxEmpty, iRxData, iTxFull,
        input  oRxPop, oEchoData, oEchoPush, oCmd, oValue, oDigitCnt, oValid, oErr, oBusy
    );
endinterface

// File: rtl/ascii_cmd_decoder.sv
// Parses "<letter><digits><CR|LF>" lines popped from the UART RX FIFO into command/value strobes.
// Optional byte echo to the TX FIFO is enabled by defining ASCII_DEC_ECHO_EN.
module ascii_cmd_decoder #(
    parameter int MAX_DIGITS = 4,
    parameter int VAL_W      = 14
) (
    input logic                 iClk,
    input logic                 iRst,
    ascii_cmd_decoder_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, POP, LATCH} state_t;

    state_t           state, stateNext;
    logic             rxPopQ;

    logic             hasCmd, hasCmdN;
    logic             errFlag, errFlagN;
    logic [VAL_W-1:0] acc, accN;
    logic [2:0]       cnt, cntN;
    logic [7:0]       lineCmd, lineCmdN;
    logic             validN, errN;

    logic [7:0]       cmdQ;
    logic [VAL_W-1:0] valueQ;
    logic [2:0]       digitCntQ;
    logic             validQ, errQ, busyQ;

    logic [7:0] rxByte;
    logic       isTerm, isLetter, isDigit;

    assign rxByte   = bus.iRxData;
    assign isTerm   = (rxByte == 8'h0D) || (rxByte == 8'h0A);
    assign isLetter = ((rxByte >= 8'h41) && (rxByte <= 8'h5A)) ||
                      ((rxByte >= 8'h61) && (rxByte <= 8'h7A));
    assign isDigit  = (rxByte >= 8'h30) && (rxByte <= 8'h39);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state  <= IDLE;
            rxPopQ <= 1'b0;
        end else begin
            state  <= stateNext;
            rxPopQ <= (stateNext == POP);
        end
    end

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (!bus.iRxEmpty) stateNext = POP;
            POP:     stateNext = LATCH;
            LATCH:   stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        hasCmdN  = hasCmd;
        errFlagN = errFlag;
        accN     = acc;
        cntN     = cnt;
        lineCmdN = lineCmd;
        validN   = 1'b0;
        errN     = 1'b0;
        if (state == LATCH) begin
            if (isTerm) begin
                validN   = hasCmd && !errFlag;
                errN     = errFlag;
                hasCmdN  = 1'b0;
                errFlagN = 1'b0;
                accN     = '0;
                cntN     = '0;
            end else if ((rxByte == 8'h20) || errFlag) begin
                // Spaces are transparent; after an error everything up to the terminator is dropped.
            end else if (isLetter) begin
                if (!hasCmd) begin
                    lineCmdN = rxByte & 8'hDF;
                    hasCmdN  = 1'b1;
                    accN     = '0;
                    cntN     = '0;
                end else begin
                    errFlagN = 1'b1;
                end
            end else if (isDigit) begin
                if (hasCmd && (cnt < 3'(MAX_DIGITS))) begin
                    accN = (acc << 3) + (acc << 1) + VAL_W'(rxByte - 8'h30);
                    cntN = cnt + 3'd1;
                end else begin
                    errFlagN = 1'b1;
                end
            end else begin
                errFlagN = 1'b1;
            end
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            hasCmd    <= 1'b0;
            errFlag   <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            lineCmd   <= '0;
            cmdQ      <= '0;
            valueQ    <= '0;
            digitCntQ <= '0;
            validQ    <= 1'b0;
            errQ      <= 1'b0;
            busyQ     <= 1'b0;
        end else begin
            hasCmd  <= hasCmdN;
            errFlag <= errFlagN;
            acc     <= accN;
            cnt     <= cntN;
            lineCmd <= lineCmdN;
            validQ  <= validN;
            errQ    <= errN;
            busyQ   <= hasCmdN | errFlagN;
            // Result fields change only on an accepted line and hold between strobes.
            if (validN) begin
                cmdQ      <= lineCmd;
                valueQ    <= acc;
                digitCntQ <= cnt;
            end
        end
    end

    assign bus.oRxPop    = rxPopQ;
    assign bus.oCmd      = cmdQ;
    assign bus.oValue    = valueQ;
    assign bus.oDigitCnt = digitCntQ;
    assign bus.oValid    = validQ;
    assign bus.oErr      = errQ;
    assign bus.oBusy     = busyQ;

`ifdef ASCII_DEC_ECHO_EN
    logic [7:0] echoDataQ;
    logic       echoPushQ;

    // A full TX FIFO drops the echo byte; the parser never stalls on it.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            echoDataQ <= '0;
            echoPushQ <= 1'b0;
        end else begin
            echoPushQ <= (state == LATCH) && !bus.iTxFull;
            if ((state == LATCH) && !bus.iTxFull) echoDataQ <= rxByte;
        end
    end

    assign bus.oEchoData = echoDataQ;
    assign bus.oEchoPush = echoPushQ;
`else
    assign bus.oEchoData = 8'h00;
    assign bus.oEchoPush = 1'b0;
`endif

endmodule
